// File: rtl/tlc_pkg.sv
// Shared definitions for the two-approach traffic phase scheduler.
//   - tlc_state_e : phase encoding, also exported on the phase output
//   - LAMP_*_IDX  : bit positions inside a 3-bit {red, yellow, green} lamp group
//   - *_DEF       : default timing parameters (ticks, and clk cycles per tick)
package tlc_pkg;

  typedef enum logic [2:0] {
    S_AG = 3'd0,
    S_AY = 3'd1,
    S_AR = 3'd2,
    S_BG = 3'd3,
    S_BY = 3'd4,
    S_BR = 3'd5,
    S_EM = 3'd6
  } tlc_state_e;

  localparam int LAMP_R_IDX = 2;
  localparam int LAMP_Y_IDX = 1;
  localparam int LAMP_G_IDX = 0;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int TICK_DIV_DEF = 50;
  localparam int GREEN_T_DEF  = 10;
  localparam int MIN_GRN_DEF  = 4;
  localparam int YELLOW_T_DEF = 4;
  localparam int ALLRED_T_DEF = 4;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/tlc_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clk cycles.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, count returns to 0
//   clr   : synchronous clear; restarts the count so a new phase sees a full
//           TICK_DIV cycles before its first tick
//   tick  : high while the count equals TICK_DIV-1
module tlc_tick_gen #(
  parameter int TICK_DIV = 50,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Timed phase sequencer for a two-approach intersection with pedestrian
// early-termination and emergency preemption.
//   clk, reset            : clock, asynchronous active-high reset
//   ped_req[1:0]          : bit0 crosses during A green, bit1 during B green
//   emerg_req, emerg_dir  : preempt request (level), direction (0=A, 1=B)
//   t12_r/y/g, t34_r/y/g  : lamp drivers for approaches A and B
//   walk[1:0]             : walk signals, index matches ped_req
//   ped_pend[1:0]         : latched pending pedestrian requests
//   emerg_act             : high while in S_EM
//   phase, phase_tmr      : current state and ticks elapsed in it (debug view)
// All outputs are decoded from registered state only.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int MIN_GRN  = MIN_GRN_DEF,
  parameter int YELLOW_T = YELLOW_T_DEF,
  parameter int ALLRED_T = ALLRED_T_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ped_req,
  input  logic             emerg_req,
  input  logic             emerg_dir,
  output logic             t12_r,
  output logic             t12_y,
  output logic             t12_g,
  output logic             t34_r,
  output logic             t34_y,
  output logic             t34_g,
  output logic [1:0]       walk,
  output logic [1:0]       ped_pend,
  output logic             emerg_act,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] phase_tmr
);

  localparam logic [CNT_W-1:0] GRN_END = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] MIN_END = CNT_W'(MIN_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_END = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] RED_END = CNT_W'(ALLRED_T - 1);

  tlc_state_e       state_q, state_d;
  logic [CNT_W-1:0] tmr_q;
  logic             em_dir_q;
  logic [1:0]       walk_q;
  logic [1:0]       ped_pend_q, ped_pend_d;
  logic             tick;
  logic             state_chg;
  logic             enter_ag, enter_bg, enter_em;
  logic [2:0]       lamp_a, lamp_b;

  assign state_chg = (state_d != state_q);
  assign enter_ag  = state_chg && (state_d == S_AG);
  assign enter_bg  = state_chg && (state_d == S_BG);
  assign enter_em  = state_chg && (state_d == S_EM);

  tlc_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (state_chg),
    .tick  (tick)
  );

  // Next-state logic. A green can be cut short by a pending request for the
  // crossing that conflicts with it (ped_pend[1] ends A green, ped_pend[0]
  // ends B green), but only once MIN_GRN ticks have been served.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_AG: begin
        if (emerg_req) begin
          state_d = S_AY;
        end else if (tick && (tmr_q == GRN_END || (ped_pend_q[1] && tmr_q >= MIN_END))) begin
          state_d = S_AY;
        end
      end
      S_AY: if (tick && tmr_q == YEL_END) state_d = S_AR;
      S_AR: if (tick && tmr_q == RED_END) state_d = emerg_req ? S_EM : S_BG;
      S_BG: begin
        if (emerg_req) begin
          state_d = S_BY;
        end else if (tick && (tmr_q == GRN_END || (ped_pend_q[0] && tmr_q >= MIN_END))) begin
          state_d = S_BY;
        end
      end
      S_BY: if (tick && tmr_q == YEL_END) state_d = S_BR;
      S_BR: if (tick && tmr_q == RED_END) state_d = emerg_req ? S_EM : S_AG;
      S_EM: if (!emerg_req) state_d = em_dir_q ? S_BY : S_AY;
      default: state_d = S_BR;
    endcase
  end

  // Entering a green clears that crossing's pending bit; a request still
  // held on the entry cycle is already served by the walk snapshot and
  // re-latches on the following cycle.
  always_comb begin
    ped_pend_d = ped_pend_q | ped_req;
    if (enter_ag) ped_pend_d[0] = 1'b0;
    if (enter_bg) ped_pend_d[1] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_BR;
      tmr_q      <= '0;
      em_dir_q   <= 1'b0;
      walk_q     <= 2'b00;
      ped_pend_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      if (state_chg) begin
        tmr_q <= '0;
      end else if (tick && state_q != S_EM) begin
        tmr_q <= tmr_q + CNT_W'(1);
      end
      if (enter_em) em_dir_q  <= emerg_dir;
      if (enter_ag) walk_q[0] <= ped_pend_q[0] | ped_req[0];
      if (enter_bg) walk_q[1] <= ped_pend_q[1] | ped_req[1];
    end
  end

  // Lamp decode: exactly one lamp per approach in every state.
  always_comb begin
    lamp_a = LAMP_RED;
    lamp_b = LAMP_RED;
    case (state_q)
      S_AG: lamp_a = LAMP_GRN;
      S_AY: lamp_a = LAMP_YEL;
      S_BG: lamp_b = LAMP_GRN;
      S_BY: lamp_b = LAMP_YEL;
      S_EM: begin
        if (em_dir_q) lamp_b = LAMP_GRN;
        else          lamp_a = LAMP_GRN;
      end
      default: begin
        lamp_a = LAMP_RED;
        lamp_b = LAMP_RED;
      end
    endcase
  end

  assign t12_r = lamp_a[LAMP_R_IDX];
  assign t12_y = lamp_a[LAMP_Y_IDX];
  assign t12_g = lamp_a[LAMP_G_IDX];
  assign t34_r = lamp_b[LAMP_R_IDX];
  assign t34_y = lamp_b[LAMP_Y_IDX];
  assign t34_g = lamp_b[LAMP_G_IDX];

  assign walk[0]   = (state_q == S_AG) && walk_q[0];
  assign walk[1]   = (state_q == S_BG) && walk_q[1];
  assign ped_pend  = ped_pend_q;
  assign emerg_act = (state_q == S_EM);
  assign phase     = state_q;
  assign phase_tmr = tmr_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler with TICK_DIV=4 (one tick = 4 clk),
// so dwells are GREEN 40, YELLOW 16, ALL-RED 16 cycles.
module tb_tlc_phase_scheduler;
  import tlc_pkg::*;

  localparam int CW = 8;
  // Lamp vectors in the order {t12_r,t12_y,t12_g,t34_r,t34_y,t34_g}
  localparam logic [5:0] L_AG = 6'b001_100;
  localparam logic [5:0] L_AY = 6'b010_100;
  localparam logic [5:0] L_RR = 6'b100_100;
  localparam logic [5:0] L_BG = 6'b100_001;
  localparam logic [5:0] L_BY = 6'b100_010;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    ped_req = 2'b00;
  logic          emerg_req = 1'b0;
  logic          emerg_dir = 1'b0;
  logic          t12_r, t12_y, t12_g, t34_r, t34_y, t34_g;
  logic [1:0]    walk, ped_pend;
  logic          emerg_act;
  logic [2:0]    phase;
  logic [CW-1:0] phase_tmr;
  logic [5:0]    lamps;

  int n_cmp = 0;
  int n_bad = 0;

  assign lamps = {t12_r, t12_y, t12_g, t34_r, t34_y, t34_g};

  always #5 clk = ~clk;

  tlc_phase_scheduler #(
    .TICK_DIV (4),
    .GREEN_T  (10),
    .MIN_GRN  (4),
    .YELLOW_T (4),
    .ALLRED_T (4),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ped_req   (ped_req),
    .emerg_req (emerg_req),
    .emerg_dir (emerg_dir),
    .t12_r     (t12_r),
    .t12_y     (t12_y),
    .t12_g     (t12_g),
    .t34_r     (t34_r),
    .t34_y     (t34_y),
    .t34_g     (t34_g),
    .walk      (walk),
    .ped_pend  (ped_pend),
    .emerg_act (emerg_act),
    .phase     (phase),
    .phase_tmr (phase_tmr)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // From a negedge, count cycles until phase changes (bounded).
  task automatic wait_change(output int n);
    logic [2:0] p;
    p = phase;
    n = 0;
    while (phase === p && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(2);
    n_cmp++; if (phase !== S_BR) begin n_bad++; $display("FAIL rst_phase: got %0d want %0d", phase, S_BR); end
    n_cmp++; if (lamps !== L_RR) begin n_bad++; $display("FAIL rst_lamps: got %b want %b", lamps, L_RR); end
    n_cmp++; if (phase_tmr !== 8'd0) begin n_bad++; $display("FAIL rst_tmr: got %0d want 0", phase_tmr); end
    n_cmp++; if ({walk, ped_pend, emerg_act} !== 5'b0) begin n_bad++; $display("FAIL rst_misc: got %b want 00000", {walk, ped_pend, emerg_act}); end
  endtask

  task automatic test_rotation();
    int n;
    reset = 1'b0;
    wait_change(n);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL rot_br_len: got %0d want 16", n); end
    n_cmp++; if (phase !== S_AG || lamps !== L_AG) begin n_bad++; $display("FAIL rot_ag: got %0d/%b want %0d/%b", phase, lamps, S_AG, L_AG); end
    n_cmp++; if (walk !== 2'b00) begin n_bad++; $display("FAIL rot_ag_walk: got %b want 00", walk); end
    wait_change(n);
    n_cmp++; if (n !== 40) begin n_bad++; $display("FAIL rot_ag_len: got %0d want 40", n); end
    n_cmp++; if (phase !== S_AY || lamps !== L_AY) begin n_bad++; $display("FAIL rot_ay: got %0d/%b want %0d/%b", phase, lamps, S_AY, L_AY); end
    wait_change(n);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL rot_ay_len: got %0d want 16", n); end
    n_cmp++; if (phase !== S_AR || lamps !== L_RR) begin n_bad++; $display("FAIL rot_ar: got %0d/%b want %0d/%b", phase, lamps, S_AR, L_RR); end
    wait_change(n);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL rot_ar_len: got %0d want 16", n); end
    n_cmp++; if (phase !== S_BG || lamps !== L_BG) begin n_bad++; $display("FAIL rot_bg: got %0d/%b want %0d/%b", phase, lamps, S_BG, L_BG); end
    wait_change(n);
    n_cmp++; if (n !== 40) begin n_bad++; $display("FAIL rot_bg_len: got %0d want 40", n); end
    n_cmp++; if (phase !== S_BY || lamps !== L_BY) begin n_bad++; $display("FAIL rot_by: got %0d/%b want %0d/%b", phase, lamps, S_BY, L_BY); end
    wait_change(n);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL rot_by_len: got %0d want 16", n); end
    n_cmp++; if (phase !== S_BR || lamps !== L_RR) begin n_bad++; $display("FAIL rot_br: got %0d/%b want %0d/%b", phase, lamps, S_BR, L_RR); end
    wait_change(n);
    n_cmp++; if (n !== 16 || phase !== S_AG) begin n_bad++; $display("FAIL rot_back_to_ag: got %0d/%0d want 16/%0d", n, phase, S_AG); end
  endtask

  // Starts on the first negedge of S_AG.
  task automatic test_ped_early();
    int n;
    step(5);
    n_cmp++; if (phase_tmr !== 8'd1) begin n_bad++; $display("FAIL ped_tmr1: got %0d want 1", phase_tmr); end
    ped_req = 2'b10;
    step(1);
    ped_req = 2'b00;
    n_cmp++; if (ped_pend !== 2'b10) begin n_bad++; $display("FAIL ped_latch: got %b want 10", ped_pend); end
    wait_change(n);
    n_cmp++; if (n + 6 !== 16 || phase !== S_AY) begin n_bad++; $display("FAIL ped_ag_short: got %0d/%0d want 16/%0d", n + 6, phase, S_AY); end
    wait_change(n);
    n_cmp++; if (ped_pend !== 2'b10) begin n_bad++; $display("FAIL ped_hold_ar: got %b want 10", ped_pend); end
    wait_change(n);
    n_cmp++; if (phase !== S_BG || walk !== 2'b10) begin n_bad++; $display("FAIL ped_bg_walk: got %0d/%b want %0d/10", phase, walk, S_BG); end
    n_cmp++; if (ped_pend !== 2'b00) begin n_bad++; $display("FAIL ped_bg_clear: got %b want 00", ped_pend); end
    step(20);
    n_cmp++; if (walk !== 2'b10) begin n_bad++; $display("FAIL ped_bg_walk_mid: got %b want 10", walk); end
    wait_change(n);
    n_cmp++; if (n + 20 !== 40) begin n_bad++; $display("FAIL ped_bg_len: got %0d want 40", n + 20); end
    n_cmp++; if (phase !== S_BY || walk !== 2'b00) begin n_bad++; $display("FAIL ped_by_walk: got %0d/%b want %0d/00", phase, walk, S_BY); end
    wait_change(n);
    wait_change(n);
    n_cmp++; if (phase !== S_AG || walk !== 2'b00) begin n_bad++; $display("FAIL ped_next_ag: got %0d/%b want %0d/00", phase, walk, S_AG); end
  endtask

  // Starts on the first negedge of S_AG.
  task automatic test_emergency();
    int n;
    step(25);
    n_cmp++; if (phase_tmr !== 8'd6) begin n_bad++; $display("FAIL em_tmr6: got %0d want 6", phase_tmr); end
    emerg_req = 1'b1;
    emerg_dir = 1'b1;
    step(1);
    n_cmp++; if (phase !== S_AY || phase_tmr !== 8'd0 || lamps !== L_AY) begin n_bad++; $display("FAIL em_to_ay: got %0d/%0d/%b want %0d/0/%b", phase, phase_tmr, lamps, S_AY, L_AY); end
    wait_change(n);
    n_cmp++; if (n !== 16 || phase !== S_AR) begin n_bad++; $display("FAIL em_ay_full: got %0d/%0d want 16/%0d", n, phase, S_AR); end
    wait_change(n);
    n_cmp++; if (n !== 16 || phase !== S_EM) begin n_bad++; $display("FAIL em_ar_full: got %0d/%0d want 16/%0d", n, phase, S_EM); end
    n_cmp++; if (lamps !== L_BG || emerg_act !== 1'b1 || walk !== 2'b00) begin n_bad++; $display("FAIL em_outputs: got %b/%b/%b want %b/1/00", lamps, emerg_act, walk, L_BG); end
    emerg_dir = 1'b0;
    ped_req = 2'b01;
    step(1);
    ped_req = 2'b00;
    step(8);
    n_cmp++; if (phase !== S_EM || lamps !== L_BG) begin n_bad++; $display("FAIL em_hold: got %0d/%b want %0d/%b", phase, lamps, S_EM, L_BG); end
    n_cmp++; if (ped_pend !== 2'b01) begin n_bad++; $display("FAIL em_ped_latch: got %b want 01", ped_pend); end
    emerg_req = 1'b0;
    step(1);
    n_cmp++; if (phase !== S_BY || emerg_act !== 1'b0 || lamps !== L_BY) begin n_bad++; $display("FAIL em_release: got %0d/%b/%b want %0d/0/%b", phase, emerg_act, lamps, S_BY, L_BY); end
    wait_change(n);
    n_cmp++; if (n !== 16 || phase !== S_BR) begin n_bad++; $display("FAIL em_by_len: got %0d/%0d want 16/%0d", n, phase, S_BR); end
    wait_change(n);
    n_cmp++; if (phase !== S_AG || walk !== 2'b01 || ped_pend !== 2'b00) begin n_bad++; $display("FAIL em_ag_walk: got %0d/%b/%b want %0d/01/00", phase, walk, ped_pend, S_AG); end
  endtask

  // Starts on the first negedge of S_AG; ends inside S_EM with emerg_req held.
  task automatic test_emerg_in_yellow();
    int n;
    wait_change(n);
    n_cmp++; if (n !== 40) begin n_bad++; $display("FAIL ey_ag_len: got %0d want 40", n); end
    wait_change(n);
    wait_change(n);
    wait_change(n);
    n_cmp++; if (n !== 40 || phase !== S_BY) begin n_bad++; $display("FAIL ey_bg_len: got %0d/%0d want 40/%0d", n, phase, S_BY); end
    step(3);
    emerg_req = 1'b1;
    emerg_dir = 1'b0;
    wait_change(n);
    n_cmp++; if (n + 3 !== 16 || phase !== S_BR) begin n_bad++; $display("FAIL ey_by_full: got %0d/%0d want 16/%0d", n + 3, phase, S_BR); end
    wait_change(n);
    n_cmp++; if (n !== 16 || phase !== S_EM) begin n_bad++; $display("FAIL ey_br_full: got %0d/%0d want 16/%0d", n, phase, S_EM); end
    n_cmp++; if (lamps !== L_AG || emerg_act !== 1'b1) begin n_bad++; $display("FAIL ey_em_lamps: got %b/%b want %b/1", lamps, emerg_act, L_AG); end
  endtask

  // Asynchronous reset mid-cycle while in S_EM; leaves reset asserted.
  task automatic test_reset_in_em();
    step(2);
    #2;
    reset = 1'b1;
    emerg_req = 1'b0;
    #1;
    n_cmp++; if (phase !== S_BR || lamps !== L_RR) begin n_bad++; $display("FAIL rem_state: got %0d/%b want %0d/%b", phase, lamps, S_BR, L_RR); end
    n_cmp++; if (emerg_act !== 1'b0 || phase_tmr !== 8'd0 || walk !== 2'b00 || ped_pend !== 2'b00) begin n_bad++; $display("FAIL rem_misc: got %b/%0d/%b/%b want 0/0/00/00", emerg_act, phase_tmr, walk, ped_pend); end
    step(2);
  endtask

  // Releases reset with ped_req[0] held through S_AG entry.
  task automatic test_ped_hold();
    int n;
    ped_req = 2'b01;
    reset = 1'b0;
    wait_change(n);
    n_cmp++; if (n !== 16 || phase !== S_AG) begin n_bad++; $display("FAIL ph_br_len: got %0d/%0d want 16/%0d", n, phase, S_AG); end
    n_cmp++; if (walk !== 2'b01 || ped_pend !== 2'b00) begin n_bad++; $display("FAIL ph_entry: got walk %b pend %b want 01/00", walk, ped_pend); end
    step(1);
    n_cmp++; if (ped_pend !== 2'b01) begin n_bad++; $display("FAIL ph_relatch: got %b want 01", ped_pend); end
    ped_req = 2'b00;
    step(1);
    wait_change(n);
    n_cmp++; if (n + 2 !== 40) begin n_bad++; $display("FAIL ph_ag_len: got %0d want 40", n + 2); end
    wait_change(n);
    wait_change(n);
    n_cmp++; if (phase !== S_BG || walk !== 2'b00) begin n_bad++; $display("FAIL ph_bg: got %0d/%b want %0d/00", phase, walk, S_BG); end
    wait_change(n);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL ph_bg_short: got %0d want 16", n); end
    wait_change(n);
    wait_change(n);
    n_cmp++; if (phase !== S_AG || walk !== 2'b01 || ped_pend !== 2'b00) begin n_bad++; $display("FAIL ph_next_ag: got %0d/%b/%b want %0d/01/00", phase, walk, ped_pend, S_AG); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rotation();
    test_ped_early();
    test_emergency();
    test_emerg_in_yellow();
    test_reset_in_em();
    test_ped_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
